// File: rtl/accu_window.sv
// accu_window: multi-channel tumbling-window accumulator.
//
// Each of n_ch channels sums win_len accepted samples, either as a signed
// sum (mode=0) or as a sum of magnitudes (mode=1). The mode is captured with
// the first sample of every window, so changing it mid-window only affects
// the next window. When the last sample of a window is accepted, the full
// window sums are written to dout and data_valid pulses for one cycle. dout
// then holds until the next window completes.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   en          sample strobe; din accepted on a rising clk edge while en=1
//   clr         synchronous window abort; drops partial sums and count
//   mode        0 = signed sum, 1 = sum of absolute values
//   din         packed signed samples, channel k at [k*input_width +: input_width]
//   dout        packed signed window results, channel k at [k*output_width +: output_width]
//   data_valid  one-cycle pulse in the cycle dout carries a new result
//   sample_cnt  number of samples accepted so far in the current window
module accu_window #(
   parameter int unsigned input_width = 37,
   parameter int unsigned n_ch        = 4,
   parameter int unsigned win_len     = 256,
   // One extra bit over the bit-growth of win_len additions leaves room for
   // win_len * 2^(input_width-1), the largest magnitude sum.
   localparam int unsigned output_width = input_width + $clog2(win_len) + 1,
   localparam int unsigned cnt_width    = $clog2(win_len)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         clr,
   input  logic                         mode,
   input  logic [n_ch*input_width-1:0]  din,
   output logic [n_ch*output_width-1:0] dout,
   output logic                         data_valid,
   output logic [cnt_width-1:0]         sample_cnt
);

   localparam logic [cnt_width-1:0] last_cnt = cnt_width'(win_len - 1);

   // Architectural state.
   logic signed [output_width-1:0] acc_q  [n_ch];
   logic signed [output_width-1:0] acc_d  [n_ch];
   logic signed [output_width-1:0] dout_q [n_ch];
   logic signed [output_width-1:0] dout_d [n_ch];
   logic [cnt_width-1:0]           cnt_q, cnt_d;
   logic                           mode_q, mode_d;
   logic                           valid_q, valid_d;

   // Per-channel contribution of the sample currently on din.
   logic signed [output_width-1:0] contrib [n_ch];

   logic first_sample;
   logic last_sample;
   logic eff_mode;

   assign first_sample = (cnt_q == '0);
   assign last_sample  = (cnt_q == last_cnt);

   // The first sample of a window is accumulated in the same edge that latches
   // the mode, so it must already use the live mode input.
   assign eff_mode = first_sample ? mode : mode_q;

   for (genvar k = 0; k < n_ch; k++) begin : g_ch
      logic signed [input_width-1:0]  smp;
      logic signed [output_width-1:0] smp_ext;

      assign smp     = din[k*input_width +: input_width];
      assign smp_ext = {{(output_width - input_width){smp[input_width-1]}}, smp};

      // Negation is done after widening, so the most negative input maps to
      // +2^(input_width-1) instead of wrapping back to itself.
      assign contrib[k] = (eff_mode && smp[input_width-1]) ? -smp_ext : smp_ext;

      assign dout[k*output_width +: output_width] = dout_q[k];
   end

   // Next-state logic. clr takes priority over en, so a sample presented
   // together with clr is discarded even on the window-completing edge.
   always_comb begin
      acc_d   = acc_q;
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      valid_d = 1'b0;

      if (clr) begin
         for (int k = 0; k < n_ch; k++) begin
            acc_d[k] = '0;
         end
         cnt_d = '0;
      end else if (en) begin
         if (first_sample) begin
            mode_d = mode;
         end

         if (last_sample) begin
            // Window complete: publish the totals and restart with no idle
            // cycle, so back-to-back windows pulse every win_len samples.
            for (int k = 0; k < n_ch; k++) begin
               dout_d[k] = acc_q[k] + contrib[k];
               acc_d[k]  = '0;
            end
            cnt_d   = '0;
            valid_d = 1'b1;
         end else begin
            for (int k = 0; k < n_ch; k++) begin
               acc_d[k] = acc_q[k] + contrib[k];
            end
            cnt_d = cnt_q + cnt_width'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < n_ch; k++) begin
            acc_q[k]  <= '0;
            dout_q[k] <= '0;
         end
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         for (int k = 0; k < n_ch; k++) begin
            acc_q[k]  <= acc_d[k];
            dout_q[k] <= dout_d[k];
         end
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         valid_q <= valid_d;
      end
   end

   assign data_valid = valid_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_accu_window.sv
// Testbench for accu_window with input_width=8, n_ch=2, win_len=4.
// Directed table of vectors with hand-computed expectations, hand-written
// asynchronous reset sequences, then random traffic against a queue-based
// window model.
module tb_accu_window;

   localparam int IW = 8;
   localparam int NC = 2;
   localparam int WL = 4;
   localparam int OW = 11;
   localparam int CW = 2;

   logic              test_clk = 1'b0;
   logic              rst      = 1'b0;
   logic              en       = 1'b0;
   logic              clr      = 1'b0;
   logic              mode     = 1'b0;
   logic [NC*IW-1:0]  din      = '0;
   logic [NC*OW-1:0]  dout;
   logic              data_valid;
   logic [CW-1:0]     sample_cnt;

   int tests = 0;
   int fails = 0;

   always #5 test_clk = ~test_clk;

   accu_window #(
      .input_width (IW),
      .n_ch        (NC),
      .win_len     (WL)
   ) dut (
      .clk        (test_clk),
      .rst        (rst),
      .en         (en),
      .clr        (clr),
      .mode       (mode),
      .din        (din),
      .dout       (dout),
      .data_valid (data_valid),
      .sample_cnt (sample_cnt)
   );

   // ---------------------------------------------------------------- helpers
   function automatic logic [NC*IW-1:0] pack(input int x0, input int x1);
      logic [IW-1:0] a;
      logic [IW-1:0] b;
      a = x0[IW-1:0];
      b = x1[IW-1:0];
      return {b, a};
   endfunction

   function automatic int chan(input int k);
      logic signed [OW-1:0] v;
      v = dout[k*OW +: OW];
      return int'(v);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input int v, input int o0, input int o1,
                            input int c);
      check({tag, " data_valid"}, int'(data_valid), v);
      check({tag, " dout0"}, chan(0), o0);
      check({tag, " dout1"}, chan(1), o1);
      check({tag, " sample_cnt"}, int'(sample_cnt), c);
   endtask

   // Apply inputs, then sample 1 time unit after the next rising edge.
   task automatic drive(input bit e, input bit c, input bit m, input int x0, input int x1);
      en   = e;
      clr  = c;
      mode = m;
      din  = pack(x0, x1);
      @(posedge test_clk);
      #1;
   endtask

   // ----------------------------------------------------------- window model
   // Keeps the raw samples of the open window and sums them when it fills.
   int m_q0[$];
   int m_q1[$];
   bit m_mode;
   int m_o0;
   int m_o1;
   int m_v;

   function automatic int wsum(input int q[$], input bit absm);
      int s = 0;
      foreach (q[i]) s += (absm && q[i] < 0) ? -q[i] : q[i];
      return s;
   endfunction

   function automatic void model_reset();
      m_q0.delete();
      m_q1.delete();
      m_mode = 1'b0;
      m_o0   = 0;
      m_o1   = 0;
      m_v    = 0;
   endfunction

   function automatic void model_step(input bit e, input bit c, input bit m,
                                      input int x0, input int x1);
      m_v = 0;
      if (c) begin
         m_q0.delete();
         m_q1.delete();
      end else if (e) begin
         if (m_q0.size() == 0) m_mode = m;
         m_q0.push_back(x0);
         m_q1.push_back(x1);
         if (m_q0.size() == WL) begin
            m_o0 = wsum(m_q0, m_mode);
            m_o1 = wsum(m_q1, m_mode);
            m_v  = 1;
            m_q0.delete();
            m_q1.delete();
         end
      end
   endfunction

   // ---------------------------------------------------------- vector table
   typedef struct {
      bit en;
      bit clr;
      bit mode;
      int d0;
      int d1;
      int v;
      int o0;
      int o1;
      int cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit e, input bit c, input bit m, input int x0,
                               input int x1, input int v, input int o0, input int o1,
                               input int cnt);
      vec_t r;
      r.en = e; r.clr = c; r.mode = m; r.d0 = x0; r.d1 = x1;
      r.v = v; r.o0 = o0; r.o1 = o1; r.cnt = cnt;
      tbl.push_back(r);
   endfunction

   function automatic void fill_table();
      // Signed window, then a second back-to-back window.
      add(1, 0, 0,  10, -5, 0,  0,   0, 1);
      add(1, 0, 0,  -3, -5, 0,  0,   0, 2);
      add(1, 0, 0,   7, -5, 0,  0,   0, 3);
      add(1, 0, 0,   1, -5, 1, 15, -20, 0);
      add(1, 0, 0,   1,  0, 0, 15, -20, 1);
      add(1, 0, 0,   1,  0, 0, 15, -20, 2);
      add(1, 0, 0,   1,  0, 0, 15, -20, 3);
      add(1, 0, 0,   1,  0, 1,  4,   0, 0);
      // Extremes, magnitude mode then signed mode.
      add(1, 0, 1, -128,  127, 0,   4,   0, 1);
      add(1, 0, 1, -128, -127, 0,   4,   0, 2);
      add(1, 0, 1, -128,    0, 0,   4,   0, 3);
      add(1, 0, 1, -128,   -1, 1, 512, 255, 0);
      add(1, 0, 0, -128,  127, 0, 512, 255, 1);
      add(1, 0, 0, -128, -127, 0, 512, 255, 2);
      add(1, 0, 0, -128,    0, 0, 512, 255, 3);
      add(1, 0, 0, -128,   -1, 1, -512, -1, 0);
      // Samples separated by en=0 gaps carrying junk data.
      for (int i = 0; i < 4; i++) begin
         add(1, 0, 0, 2, 0, (i == 3) ? 1 : 0, (i == 3) ? 8 : -512, (i == 3) ? 0 : -1,
             (i + 1) % 4);
         if (i < 3) begin
            for (int j = 0; j < 3; j++) add(0, 0, 1, 99, -77, 0, -512, -1, i + 1);
         end
      end
      add(0, 0, 0, 0, 0, 0, 8, 0, 0);
      // Abort after two samples, then a clean window.
      add(1, 0, 0, 50, 0, 0, 8, 0, 1);
      add(1, 0, 0, 50, 0, 0, 8, 0, 2);
      add(0, 1, 0,  0, 0, 0, 8, 0, 0);
      for (int i = 0; i < 4; i++) begin
         add(1, 0, 0, 1, 0, (i == 3) ? 1 : 0, (i == 3) ? 4 : 8, 0, (i + 1) % 4);
      end
      // clr coincident with what would be the completing sample.
      for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, 0, 4, 0, i + 1);
      add(1, 1, 0, 1, 0, 0, 4, 0, 0);
      add(0, 0, 0, 0, 0, 0, 4, 0, 0);
      // Mode changed mid-window only affects the following window.
      add(1, 0, 0, -1, 0, 0,  4, 0, 1);
      add(1, 0, 0, -1, 0, 0,  4, 0, 2);
      add(1, 0, 1, -1, 0, 0,  4, 0, 3);
      add(1, 0, 1, -1, 0, 1, -4, 0, 0);
      add(1, 0, 1, -1, 0, 0, -4, 0, 1);
      add(1, 0, 1, -1, 0, 0, -4, 0, 2);
      add(1, 0, 0, -1, 0, 0, -4, 0, 3);
      add(1, 0, 0, -1, 0, 1,  4, 0, 0);
   endfunction

   // ------------------------------------------------------------- stimulus
   initial begin
      int s0[4];
      bit rm;

      // Reset held for 3 cycles, then 5 idle cycles.
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge test_clk);
         #1;
         check_out("reset", 0, 0, 0, 0);
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0);
         check_out("idle", 0, 0, 0, 0);
      end

      fill_table();
      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].clr, tbl[i].mode, tbl[i].d0, tbl[i].d1);
         check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].o0, tbl[i].o1, tbl[i].cnt);
      end

      // Build dout=15, then assert reset between edges after 3 samples.
      s0 = '{10, -3, 7, 1};
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, s0[i], 0);
         check_out("prerst", (i == 3) ? 1 : 0, (i == 3) ? 15 : 4, 0, (i + 1) % 4);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 5, 0);
         check_out("partial", 0, 15, 0, i + 1);
      end
      @(negedge test_clk);
      en  = 1'b0;
      rst = 1'b0;
      #1;
      check_out("async_rst", 0, 0, 0, 0);
      @(posedge test_clk);
      #1;
      check_out("rst_hold", 0, 0, 0, 0);
      @(negedge test_clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 3, 0);
         check_out("post_rst", (i == 3) ? 1 : 0, (i == 3) ? 12 : 0, 0, (i + 1) % 4);
      end
      drive(0, 0, 0, 0, 0);
      check_out("post_rst_idle", 0, 12, 0, 0);

      // Random traffic against the window model, from a fresh reset.
      @(negedge test_clk);
      rst = 1'b0;
      #1;
      model_reset();
      @(negedge test_clk);
      rst = 1'b1;
      rm  = 1'b0;
      for (int n = 0; n < 600; n++) begin
         bit e;
         bit c;
         logic signed [IW-1:0] r0;
         logic signed [IW-1:0] r1;
         e  = ($urandom_range(0, 9) < 7);
         c  = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) rm = ~rm;
         r0 = ($urandom_range(0, 7) == 0) ? -8'sd128 : IW'($urandom);
         r1 = ($urandom_range(0, 7) == 0) ? -8'sd128 : IW'($urandom);
         drive(e, c, rm, int'(r0), int'(r1));
         model_step(e, c, rm, int'(r0), int'(r1));
         check_out($sformatf("rand%0d", n), m_v, m_o0, m_o1, m_q0.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
